// File: rtl/rans_stream_encoder.sv
// rans_stream_encoder: table-driven streaming rANS encoder with word renormalisation,
// an iterative restoring divider for the state update, and a framed flush of the final state.
module rans_stream_encoder #(
    parameter int SYMBOL_WIDTH = 4,
    parameter int LOG_M        = 10,
    parameter int STATE_WIDTH  = 32,
    parameter int OUT_WIDTH    = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    config_en,
    input  logic [SYMBOL_WIDTH-1:0] config_symbol,
    input  logic [LOG_M:0]          config_freq,
    input  logic [LOG_M-1:0]        config_cumul,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SYMBOL_WIDTH-1:0] in_symbol,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_WIDTH-1:0]    out_data,
    output logic                    out_last,
    output logic                    busy,
    output logic                    err
);
    localparam int NS = 2 ** SYMBOL_WIDTH;
    localparam int NW = STATE_WIDTH / OUT_WIDTH;
    localparam int CW = $clog2(STATE_WIDTH);
    localparam logic [STATE_WIDTH-1:0] L = STATE_WIDTH'(1) << (STATE_WIDTH - OUT_WIDTH);

    typedef enum logic [2:0] {IDLE, RENORM, DIVIDE, UPDATE, FLUSH} state_t;

    state_t                 state;
    logic [LOG_M:0]         freq_tab  [NS];
    logic [LOG_M-1:0]       cumul_tab [NS];
    logic [STATE_WIDTH-1:0] x, quo;
    logic [LOG_M:0]         f, rem;
    logic [LOG_M-1:0]       c;
    logic                   last;
    logic [CW-1:0]          cnt;

    logic [STATE_WIDTH:0]   x_max;
    logic [STATE_WIDTH-1:0] x_sh, x_upd;
    logic [LOG_M+1:0]       trial;
    logic                   fits;

    assign in_ready = rst_n && state == IDLE && !config_en;
    assign busy     = state != IDLE;
    assign x_max    = {f, {(STATE_WIDTH - LOG_M){1'b0}}};
    assign x_sh     = x >> OUT_WIDTH;
    assign trial    = {rem, quo[STATE_WIDTH-1]};
    assign fits     = trial >= {1'b0, f};
    assign x_upd    = (quo << LOG_M) + STATE_WIDTH'(rem) + STATE_WIDTH'(c);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            x         <= L;
            quo       <= '0;
            rem       <= '0;
            f         <= '0;
            c         <= '0;
            last      <= 1'b0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            err       <= 1'b0;
            for (int i = 0; i < NS; i++) begin
                freq_tab[i]  <= '0;
                cumul_tab[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (config_en) begin
                        freq_tab[config_symbol]  <= config_freq;
                        cumul_tab[config_symbol] <= config_cumul;
                    end else if (in_valid) begin
                        f    <= freq_tab[in_symbol];
                        c    <= cumul_tab[in_symbol];
                        last <= in_last;
                        // A zero-frequency symbol cannot be coded: flag it and keep x intact
                        if (freq_tab[in_symbol] == '0) begin
                            err <= 1'b1;
                            if (in_last) begin
                                state     <= FLUSH;
                                out_valid <= 1'b1;
                                out_data  <= x[OUT_WIDTH-1:0];
                                out_last  <= 1'b0;
                                cnt       <= '0;
                            end
                        end else begin
                            state <= RENORM;
                        end
                    end
                end
                RENORM: begin
                    if (out_valid) begin
                        if (out_ready) begin
                            x         <= x_sh;
                            out_data  <= x_sh[OUT_WIDTH-1:0];
                            out_valid <= {1'b0, x_sh} >= x_max;
                        end
                    end else if ({1'b0, x} >= x_max) begin
                        out_valid <= 1'b1;
                        out_data  <= x[OUT_WIDTH-1:0];
                    end else begin
                        state <= DIVIDE;
                        quo   <= x;
                        rem   <= '0;
                        cnt   <= '0;
                    end
                end
                DIVIDE: begin
                    quo <= {quo[STATE_WIDTH-2:0], fits};
                    rem <= fits ? (LOG_M + 1)'(trial - {1'b0, f}) : trial[LOG_M:0];
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(STATE_WIDTH - 1)) state <= UPDATE;
                end
                UPDATE: begin
                    x <= x_upd;
                    if (last) begin
                        state     <= FLUSH;
                        out_valid <= 1'b1;
                        out_data  <= x_upd[OUT_WIDTH-1:0];
                        out_last  <= 1'b0;
                        cnt       <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                FLUSH: begin
                    if (out_ready) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            x         <= L;
                            state     <= IDLE;
                        end else begin
                            x        <= x_sh;
                            out_data <= x_sh[OUT_WIDTH-1:0];
                            out_last <= cnt == CW'(NW - 2);
                            cnt      <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rans_stream_encoder.sv
// tb_rans_stream_encoder: drives symbol/config streams and compares the emitted words
// against an arithmetic rANS model of the encoder.
module tb_rans_stream_encoder;
    localparam int SW = 2, LM = 4, XW = 16, OW = 8, NW = XW / OW, L = 256, M = 16;

    logic clk = 1'b0, rst_n = 1'b1;
    logic config_en = 1'b0, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
    logic [SW-1:0] config_symbol = '0, in_symbol = '0;
    logic [LM:0] config_freq = '0;
    logic [LM-1:0] config_cumul = '0;
    logic in_ready, out_valid, out_last, busy, err;
    logic [OW-1:0] out_data;

    int checks = 0, errors = 0;
    int tf[4], tc[4];
    int mx = L;
    bit merr = 0;
    int exp_q[$], act_q[$];
    int mode = 0, stall = 0, lat;
    bit stalled = 0;
    logic [8:0] prev;

    rans_stream_encoder #(.SYMBOL_WIDTH(SW), .LOG_M(LM), .STATE_WIDTH(XW), .OUT_WIDTH(OW)) dut (
        .clk(clk), .rst_n(rst_n), .config_en(config_en), .config_symbol(config_symbol),
        .config_freq(config_freq), .config_cumul(config_cumul), .in_valid(in_valid),
        .in_ready(in_ready), .in_symbol(in_symbol), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (stalled) check("stable_while_stalled", {out_last, out_data}, prev);
            if (out_ready) begin
                act_q.push_back(int'({out_last, out_data}));
                stall   = 0;
                stalled = 0;
            end else begin
                stalled = 1;
                prev    = {out_last, out_data};
            end
        end else begin
            stalled = 0;
        end
    end

    always @(posedge clk) begin
        #1;
        if (mode == 0) out_ready = 1'b1;
        else if (mode == 1) out_ready = $urandom_range(0, 3) != 0;
        else begin
            out_ready = !(out_valid && stall < 5);
            if (out_valid && stall < 5) stall++;
        end
    end

    // Reference: renormalise while x >= f*2^(XW-LM), then x = (x/f)*M + x%f + c
    task automatic model(input int s, input bit last);
        int f = tf[s];
        if (f == 0) merr = 1;
        else begin
            while (mx >= (f << (XW - LM))) begin
                exp_q.push_back(mx % 256);
                mx = mx / 256;
            end
            mx = ((mx / f) * M + mx % f + tc[s]) % 65536;
        end
        if (last) begin
            for (int i = 0; i < NW; i++)
                exp_q.push_back(((i == NW - 1) ? 256 : 0) + (mx >> (8 * i)) % 256);
            mx = L;
        end
    endtask

    task automatic cfg(input int s, input int f, input int c);
        @(posedge clk); #1;
        config_en = 1; config_symbol = SW'(s); config_freq = (LM + 1)'(f); config_cumul = LM'(c);
        @(posedge clk); #1;
        config_en = 0;
        tf[s] = f; tc[s] = c;
    endtask

    task automatic send(input int s, input bit last, output int n);
        int w = 0;
        @(posedge clk); #1;
        in_valid = 1; in_symbol = SW'(s); in_last = last;
        do begin @(negedge clk); w++; end while (!in_ready && w < 200);
        check("accept", in_ready, 1);
        model(s, last);
        @(posedge clk); #1;
        in_valid = 0;
        n = 1;
        forever begin
            @(negedge clk);
            if (in_ready || n >= 2000) break;
            n++;
        end
        check("back_to_idle", in_ready, 1);
    endtask

    task automatic compare(input string tag);
        check({tag, "_count"}, act_q.size(), exp_q.size());
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++)
            check({tag, "_word"}, act_q[i], exp_q[i]);
        act_q.delete();
        exp_q.delete();
    endtask

    task automatic model_reset();
        mx = L; merr = 0; stall = 0;
        for (int i = 0; i < 4; i++) begin tf[i] = 0; tc[i] = 0; end
        act_q.delete();
        exp_q.delete();
    endtask

    task automatic load_table();
        cfg(0, 8, 0); cfg(1, 4, 8); cfg(2, 4, 12); cfg(3, 0, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        rst_n = 0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_in_ready", in_ready, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        check("in_ready_after_rst", in_ready, 1);
        load_table();

        send(0, 0, lat); check("lat_no_renorm", lat, 19);
        send(1, 1, lat); check("lat_with_flush", lat, 21);
        compare("no_renorm");

        send(0, 0, lat); send(1, 0, lat); send(1, 0, lat); send(1, 0, lat); send(1, 1, lat);
        compare("renorm");

        mode = 2;
        send(0, 0, lat); send(1, 0, lat); send(1, 0, lat); send(1, 0, lat); send(1, 1, lat);
        compare("backpressure");
        mode = 0;

        send(3, 1, lat);
        check("err_zero_freq", err, 1);
        compare("zero_freq");
        send(0, 1, lat);
        check("err_sticky", err, 1);
        compare("after_err");

        @(posedge clk); #1 in_valid = 1; in_symbol = 0; in_last = 0;
        @(posedge clk); #1 in_valid = 0;
        repeat (3) @(posedge clk);
        #1 check("busy_in_divide", busy, 1);
        rst_n = 0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_out_data", out_data, 0);
        check("abort_out_last", out_last, 0);
        check("abort_busy", busy, 0);
        check("abort_err", err, 0);
        check("abort_in_ready", in_ready, 0);
        model_reset();
        @(posedge clk); #1 rst_n = 1;
        @(negedge clk);
        check("abort_in_ready_after", in_ready, 1);
        send(0, 1, lat);
        check("table_cleared_err", err, 1);
        compare("table_cleared");

        @(posedge clk); #1 rst_n = 0;
        model_reset();
        @(posedge clk); #1 rst_n = 1;
        load_table();
        fork
            send(0, 0, lat);
            begin
                repeat (4) @(posedge clk);
                #1 config_en = 1; config_symbol = 0; config_freq = 2; config_cumul = 0;
                @(negedge clk); check("busy_during_gated_cfg", busy, 1);
                @(posedge clk); #1 config_en = 0;
            end
        join
        @(posedge clk); #1 config_en = 1; config_symbol = 3; config_freq = 0; config_cumul = 0;
        @(negedge clk); check("in_ready_cfg_idle", in_ready, 0);
        @(posedge clk); #1 config_en = 0;
        send(0, 1, lat);
        compare("cfg_gating");

        @(posedge clk); #1 rst_n = 0;
        model_reset();
        @(posedge clk); #1 rst_n = 1;
        for (int s = 0; s < 4; s++) begin
            int f, c;
            f = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, M);
            c = $urandom_range(0, M - f);
            cfg(s, f, c);
        end
        mode = 1;
        for (int i = 0; i < 150; i++)
            send($urandom_range(0, 3), $urandom_range(0, 7) == 0, lat);
        send($urandom_range(0, 3), 1, lat);
        mode = 0;
        compare("random");
        check("random_err", err, 32'(merr));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
